// File: rtl/alu.sv
// Single-cycle 32-bit ALU with registered outputs: arithmetic, logic, shifts,
// multiply, divide and branch-condition evaluation, one new result per clock.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [4:0]  shift,
    input  logic [4:0]  op,
    output logic        bt,
    output logic [31:0] result,
    output logic [31:0] result_high
);

    typedef enum logic [4:0] {
        OP_ADD   = 5'h00,
        OP_SUB   = 5'h01,
        OP_AND   = 5'h02,
        OP_OR    = 5'h03,
        OP_XOR   = 5'h04,
        OP_NOR   = 5'h05,
        OP_SLT   = 5'h06,
        OP_SLTU  = 5'h07,
        OP_SLL   = 5'h08,
        OP_SRL   = 5'h09,
        OP_SRA   = 5'h0A,
        OP_SLLV  = 5'h0B,
        OP_SRLV  = 5'h0C,
        OP_SRAV  = 5'h0D,
        OP_LUI   = 5'h0E,
        OP_MULT  = 5'h0F,
        OP_MULTU = 5'h10,
        OP_DIV   = 5'h11,
        OP_DIVU  = 5'h12,
        OP_BEQ   = 5'h13,
        OP_BNE   = 5'h14,
        OP_BLEZ  = 5'h15,
        OP_BGTZ  = 5'h16,
        OP_BLTZ  = 5'h17,
        OP_BGEZ  = 5'h18
    } op_e;

    logic [31:0] result_d, result_q;
    logic [31:0] result_high_d, result_high_q;
    logic        bt_d, bt_q;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] in0_s, in1_s;
    logic               div_zero, div_ovf;

    assign in0_s    = $signed(in0);
    assign in1_s    = $signed(in1);
    assign prod_s   = $signed({{32{in0[31]}}, in0}) * $signed({{32{in1[31]}}, in1});
    assign prod_u   = {32'b0, in0} * {32'b0, in1};
    assign div_zero = (in1 == 32'h0);
    assign div_ovf  = (in0 == 32'h8000_0000) && (in1 == 32'hFFFF_FFFF);

    always_comb begin
        result_d      = 32'h0;
        result_high_d = 32'h0;
        bt_d          = 1'b0;
        case (op)
            OP_ADD:   result_d = in0 + in1;
            OP_SUB:   result_d = in0 - in1;
            OP_AND:   result_d = in0 & in1;
            OP_OR:    result_d = in0 | in1;
            OP_XOR:   result_d = in0 ^ in1;
            OP_NOR:   result_d = ~(in0 | in1);
            OP_SLT:   result_d = {31'b0, (in0_s < in1_s)};
            OP_SLTU:  result_d = {31'b0, (in0 < in1)};
            OP_SLL:   result_d = in1 << shift;
            OP_SRL:   result_d = in1 >> shift;
            OP_SRA:   result_d = in1_s >>> shift;
            OP_SLLV:  result_d = in1 << in0[4:0];
            OP_SRLV:  result_d = in1 >> in0[4:0];
            OP_SRAV:  result_d = in1_s >>> in0[4:0];
            OP_LUI:   result_d = {in1[15:0], 16'h0};
            OP_MULT: begin
                result_d      = prod_s[31:0];
                result_high_d = prod_s[63:32];
            end
            OP_MULTU: begin
                result_d      = prod_u[31:0];
                result_high_d = prod_u[63:32];
            end
            // Zero divisor and the single signed overflow case get fixed answers
            OP_DIV: begin
                if (div_zero) begin
                    result_d      = 32'hFFFF_FFFF;
                    result_high_d = in0;
                end else if (div_ovf) begin
                    result_d      = 32'h8000_0000;
                    result_high_d = 32'h0;
                end else begin
                    result_d      = in0_s / in1_s;
                    result_high_d = in0_s % in1_s;
                end
            end
            OP_DIVU: begin
                if (div_zero) begin
                    result_d      = 32'hFFFF_FFFF;
                    result_high_d = in0;
                end else begin
                    result_d      = in0 / in1;
                    result_high_d = in0 % in1;
                end
            end
            OP_BEQ:   bt_d = (in0 == in1);
            OP_BNE:   bt_d = (in0 != in1);
            OP_BLEZ:  bt_d = (in0_s <= 32'sd0);
            OP_BGTZ:  bt_d = (in0_s > 32'sd0);
            OP_BLTZ:  bt_d = in0[31];
            OP_BGEZ:  bt_d = ~in0[31];
            default: begin
                result_d      = 32'h0;
                result_high_d = 32'h0;
                bt_d          = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q      <= 32'h0;
            result_high_q <= 32'h0;
            bt_q          <= 1'b0;
        end else begin
            result_q      <= result_d;
            result_high_q <= result_high_d;
            bt_q          <= bt_d;
        end
    end

    assign result      = result_q;
    assign result_high = result_high_q;
    assign bt          = bt_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner vectors, then randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [4:0]  shift;
    logic [4:0]  op;
    logic        bt;
    logic [31:0] result;
    logic [31:0] result_high;

    int checkCount;
    int errorCount;

    alu dut (
        .clk         (clk),
        .rst         (rst),
        .in0         (in0),
        .in1         (in1),
        .shift       (shift),
        .op          (op),
        .bt          (bt),
        .result      (result),
        .result_high (result_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference model built on 64-bit integer arithmetic
    function automatic void refModel(input logic [4:0] fop, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] sh, output logic [31:0] r,
                                     output logic [31:0] rh, output logic t);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     wide;
        int              amt;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        r  = 32'h0;
        rh = 32'h0;
        t  = 1'b0;
        amt = (fop >= 5'h0B) ? int'(a[4:0]) : int'(sh);
        case (fop)
            5'h00: r = a + b;
            5'h01: r = a - b;
            5'h02: r = a & b;
            5'h03: r = a | b;
            5'h04: r = a ^ b;
            5'h05: r = ~(a | b);
            5'h06: r = (sa < sb) ? 32'd1 : 32'd0;
            5'h07: r = (ua < ub) ? 32'd1 : 32'd0;
            5'h08, 5'h0B: begin wide = ub << amt; r = wide[31:0]; end
            5'h09, 5'h0C: begin wide = ub >> amt; r = wide[31:0]; end
            5'h0A, 5'h0D: begin wide = sb >>> amt; r = wide[31:0]; end
            5'h0E: r = b << 16;
            5'h0F: begin wide = sa * sb; r = wide[31:0]; rh = wide[63:32]; end
            5'h10: begin wide = ua * ub; r = wide[31:0]; rh = wide[63:32]; end
            5'h11: begin
                if (b == 0) begin r = '1; rh = a; end
                else begin
                    wide = sa / sb; r = wide[31:0];
                    wide = sa % sb; rh = wide[31:0];
                end
            end
            5'h12: begin
                if (b == 0) begin r = '1; rh = a; end
                else begin
                    wide = ua / ub; r = wide[31:0];
                    wide = ua % ub; rh = wide[31:0];
                end
            end
            5'h13: t = (a == b);
            5'h14: t = (a != b);
            5'h15: t = (sa <= 0);
            5'h16: t = (sa > 0);
            5'h17: t = (sa < 0);
            5'h18: t = (sa >= 0);
            default: ;
        endcase
    endfunction

    // Drive one operation, let one rising edge capture it, then check all outputs
    task automatic applyStimulus(input string tag, input logic r, input logic [4:0] fop,
                                 input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] expR, expRh;
        logic        expT;
        rst   = r;
        op    = fop;
        in0   = a;
        in1   = b;
        shift = sh;
        refModel(fop, a, b, sh, expR, expRh, expT);
        if (r) begin
            expR  = 32'h0;
            expRh = 32'h0;
            expT  = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".result"}, result, expR);
        checkOutput({tag, ".result_high"}, result_high, expRh);
        checkOutput({tag, ".bt"}, {31'b0, bt}, {31'b0, expT});
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            4: return -$urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1; op = 5'h00; in0 = 32'h0; in1 = 32'h0; shift = 5'h0;

        applyStimulus("reset", 1'b1, 5'h00, 32'h1234, 32'h5678, 5'd3);

        for (int i = 0; i < 16; i++)
            applyStimulus("add_sweep", 1'b0, 5'h00, i, 32'd1, 5'd0);

        applyStimulus("sub_wrap", 1'b0, 5'h01, 32'h0, 32'h1, 5'd0);
        applyStimulus("slt", 1'b0, 5'h06, 32'h0, 32'h1, 5'd0);
        applyStimulus("sltu", 1'b0, 5'h07, 32'hFFFF_FFFF, 32'h1, 5'd0);
        applyStimulus("sra", 1'b0, 5'h0A, 32'h0, 32'h8000_0000, 5'd4);
        applyStimulus("srl", 1'b0, 5'h09, 32'h0, 32'h8000_0000, 5'd4);
        applyStimulus("lui", 1'b0, 5'h0E, 32'h0, 32'h1234, 5'd0);
        applyStimulus("mult", 1'b0, 5'h0F, 32'hFFFF_FFFF, 32'd2, 5'd0);
        applyStimulus("multu", 1'b0, 5'h10, 32'hFFFF_FFFF, 32'd2, 5'd0);
        applyStimulus("div", 1'b0, 5'h11, -32'sd7, 32'd2, 5'd0);
        applyStimulus("divu_zero", 1'b0, 5'h12, 32'd5, 32'd0, 5'd0);
        applyStimulus("div_zero", 1'b0, 5'h11, 32'hFFFF_FFF0, 32'd0, 5'd0);
        applyStimulus("div_ovf", 1'b0, 5'h11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        applyStimulus("beq", 1'b0, 5'h13, 32'd5, 32'd5, 5'd0);
        applyStimulus("blez", 1'b0, 5'h15, 32'd0, 32'd9, 5'd0);
        applyStimulus("reset_mid", 1'b1, 5'h13, 32'd5, 32'd5, 5'd0);
        applyStimulus("post_reset", 1'b0, 5'h0F, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0);
        applyStimulus("reserved", 1'b0, 5'h1F, 32'hDEAD_BEEF, 32'h1, 5'd7);

        for (int i = 0; i < 3000; i++)
            applyStimulus("random", ($urandom_range(0, 49) == 0), 5'($urandom_range(0, 31)),
                          pickOperand(), pickOperand(), 5'($urandom_range(0, 31)));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in0  input  32  operand A (rs); SLLV/SRLV/SRAV shift amount = in0[4:0].
REQ-005 in1  input  32  operand B (rt/immediate); value shifted by shift ops.
REQ-006 shift  input  5  shift amount (shamt) for SLL/SRL/SRA.
REQ-007 op  input  5  operation select.
REQ-008 bt  output  1  branch-taken flag, registered.
REQ-009 result  output  32  primary result / low word, registered.
REQ-010 result_high  output  32  high word (MULT*) or remainder (DIV*), registered.

Function
REQ-011 All three outputs SHALL be registered: value from inputs sampled at rising edge N SHALL appear after edge N; latency exactly 1 cycle, new result every cycle, no handshake.
REQ-012 Op encoding (hex), result = :
- 00 ADD in0+in1
- 01 SUB in0-in1
- 02 AND
- 03 OR
- 04 XOR
- 05 NOR
- 06 SLT signed in0<in1 ? 1:0
- 07 SLTU unsigned compare ? 1:0
- 08 SLL in1<<shift
- 09 SRL in1>>shift logical
- 0A SRA in1>>>shift arithmetic
- 0B SLLV / 0C SRLV / 0D SRAV as 08-0A using in0[4:0]
- 0E LUI {in1[15:0],16'h0}
REQ-013 Add/sub SHALL wrap modulo 2^32; no overflow trap or flag.
REQ-014 0F MULT signed, 10 MULTU unsigned: 64-bit product, result = product[31:0], result_high = product[63:32].
REQ-015 11 DIV signed, 12 DIVU unsigned: result = quotient truncated toward zero, result_high = remainder with sign of in0.
REQ-016 Divide by zero (in1=0): result = 32'hFFFFFFFF, result_high = in0, signed and unsigned.
REQ-017 Signed overflow DIV 0x80000000 / 0xFFFFFFFF: result = 0x80000000, result_high = 0.
REQ-018 Branch ops, bt = : 13 BEQ in0==in1; 14 BNE in0!=in1; 15 BLEZ signed in0<=0; 16 BGTZ in0>0; 17 BLTZ in0<0; 18 BGEZ in0>=0; result = 0, result_high = 0.
REQ-019 bt SHALL be 0 for all non-branch ops.
REQ-020 result_high SHALL be 0 for all ops except 0F-12.
REQ-021 Reserved ops 19-1F: result = 0, result_high = 0, bt = 0.
REQ-022 Datapath fully combinational into output registers, single cycle for every op including multiply and divide.

Reset
REQ-023 While rst=1 at a rising edge: result, result_high, bt SHALL load 0, overriding any op.
REQ-024 First edge with rst=0 SHALL load the computed value of the current inputs; no further recovery cycles.
REQ-025 Before the first reset edge, output values are unspecified.

Verification
REQ-026 op=00, in1=1, in0 swept 0..15, one op per clock -> result = in0+1 (1..16) one cycle later, bt=0, result_high=0.
REQ-027 op=01, in0=0, in1=1 -> result=0xFFFFFFFF; op=06 same operands -> 1; op=07 in0=0xFFFFFFFF, in1=1 -> 0.
REQ-028 op=0A, in1=0x80000000, shift=4 -> 0xF8000000; op=09 same -> 0x08000000; op=0E, in1=0x1234 -> 0x12340000.
REQ-029 op=0F, in0=0xFFFFFFFF, in1=2 -> result=0xFFFFFFFE, result_high=0xFFFFFFFF; op=10 same -> result=0xFFFFFFFE, result_high=1.
REQ-030 op=11, in0=-7, in1=2 -> result=-3, result_high=-1; op=12, in1=0, in0=5 -> result=0xFFFFFFFF, result_high=5.
REQ-031 op=13, in0=in1=5 -> bt=1; op=15, in0=0 -> bt=1; then rst=1 with any op -> all outputs 0 after that edge.
